// File: rtl/sva_bounded_response_monitor.sv
// In-hardware checker for trig |-> first_match(##[MIN_DLY:MAX_DLY] ready), or |=> when NONOVERLAP=1.
// Each trigger opens an attempt slot; verdicts are counted and reported one cycle after the deciding edge.
module sva_bounded_response_monitor #(
  parameter int MIN_DLY    = 0,
  parameter int MAX_DLY    = 10,
  parameter int NONOVERLAP = 0,
  parameter int MAX_OUTST  = 4,
  parameter int CNT_W      = 16,
  localparam int EMIN  = MIN_DLY + NONOVERLAP,
  localparam int EMAX  = MAX_DLY + NONOVERLAP,
  localparam int LAT_W = (EMAX > 0) ? $clog2(EMAX + 1) : 1,
  localparam int OUT_W = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear_i,
  input  logic             trig_i,
  input  logic             ready_i,
  output logic             pass_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [OUT_W-1:0] outstanding_o,
  output logic             overflow_o,
  output logic [LAT_W-1:0] last_lat_o
);
  localparam int NUM_W = $clog2(MAX_OUTST + 2);

  logic [MAX_OUTST-1:0] valid_q, valid_nxt;
  logic [LAT_W-1:0]     age_q   [MAX_OUTST];
  logic [LAT_W-1:0]     age_nxt [MAX_OUTST];
  logic [NUM_W-1:0]     n_pass, n_fail;
  logic [OUT_W-1:0]     n_open;
  logic [LAT_W-1:0]     lat_max;
  logic                 new_att, new_pass, new_fail, placed, drop;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [NUM_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // A slot's stored age is its age at the current edge; a new attempt is stored as age 1.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    valid_nxt = valid_q;
    age_nxt   = age_q;
    n_pass    = '0;
    n_fail    = '0;
    lat_max   = '0;
    n_open    = '0;
    placed    = 1'b0;
    drop      = 1'b0;
    new_att   = trig_i & en;
    new_pass  = new_att & ready_i & (EMIN == 0);
    new_fail  = new_att & ~ready_i & (EMAX == 0);
    if (new_pass) n_pass = NUM_W'(1);
    if (new_fail) n_fail = NUM_W'(1);

    for (int i = 0; i < MAX_OUTST; i++) begin
      if (valid_q[i]) begin
        if (ready_i && int'(age_q[i]) >= EMIN) begin
          valid_nxt[i] = 1'b0;
          n_pass       = n_pass + 1'b1;
          if (age_q[i] > lat_max) lat_max = age_q[i];
        end else if (!ready_i && int'(age_q[i]) == EMAX) begin
          valid_nxt[i] = 1'b0;
          n_fail       = n_fail + 1'b1;
        end else begin
          age_nxt[i] = age_q[i] + 1'b1;
        end
      end
    end

    // Slots freed above are already visible to the allocator on this edge.
    if (new_att && !new_pass && !new_fail) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        if (!placed && !valid_nxt[i]) begin
          valid_nxt[i] = 1'b1;
          age_nxt[i]   = LAT_W'(1);
          placed       = 1'b1;
        end
      end
      drop = ~placed;
    end

    for (int i = 0; i < MAX_OUTST; i++) n_open = n_open + OUT_W'(valid_nxt[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      pass_o        <= 1'b0;
      fail_o        <= 1'b0;
      pass_cnt_o    <= '0;
      fail_cnt_o    <= '0;
      outstanding_o <= '0;
      overflow_o    <= 1'b0;
      last_lat_o    <= '0;
    end else begin
      valid_q       <= valid_nxt;
      pass_o        <= (n_pass != '0);
      fail_o        <= (n_fail != '0);
      outstanding_o <= n_open;
      if (n_pass != '0) last_lat_o <= lat_max;
      if (clear_i) begin
        pass_cnt_o <= '0;
        fail_cnt_o <= '0;
        overflow_o <= 1'b0;
      end else begin
        pass_cnt_o <= sat_add(pass_cnt_o, n_pass);
        fail_cnt_o <= sat_add(fail_cnt_o, n_fail);
        if (drop) overflow_o <= 1'b1;
      end
    end
  end

  // NOTE: ages are only meaningful while valid_q is set, so this storage needs no reset.
  always_ff @(posedge clk) begin
    age_q <= age_nxt;
  end

endmodule

// File: tb/tb_sva_bounded_response_monitor.sv
// Four monitor configurations share one stimulus stream; each is compared every cycle against an
// attempt-list reference model, with directed scenarios checked against hand-derived constants.
module tb_sva_bounded_response_monitor;
  localparam int NK = 4;
  // Per-instance configuration, one byte per instance (instance 0 in the low byte).
  localparam logic [31:0] MIN_V = {8'd0,  8'd0,  8'd5,  8'd0};
  localparam logic [31:0] MAX_V = {8'd10, 8'd10, 8'd5,  8'd10};
  localparam logic [31:0] NO_V  = {8'd0,  8'd1,  8'd0,  8'd0};
  localparam logic [31:0] MO_V  = {8'd2,  8'd4,  8'd6,  8'd4};
  localparam logic [31:0] CW_V  = {8'd3,  8'd16, 8'd16, 8'd16};

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, clear = 1'b0, trig = 1'b0, ready = 1'b0;
  always #5 clk = ~clk;

  logic        obs_p [NK], obs_f [NK], obs_ovf [NK];
  logic [31:0] obs_pc [NK], obs_fc [NK], obs_out [NK], obs_lat [NK];

  for (genvar k = 0; k < NK; k++) begin : g_dut
    localparam int MIN  = int'(MIN_V[k*8 +: 8]);
    localparam int MAX  = int'(MAX_V[k*8 +: 8]);
    localparam int NO   = int'(NO_V[k*8 +: 8]);
    localparam int MO   = int'(MO_V[k*8 +: 8]);
    localparam int CW   = int'(CW_V[k*8 +: 8]);
    localparam int EMX  = MAX + NO;
    localparam int LW   = (EMX > 0) ? $clog2(EMX + 1) : 1;
    localparam int OW   = $clog2(MO + 1);
    logic          p_o, f_o, ovf_o;
    logic [CW-1:0] pc_o, fc_o;
    logic [OW-1:0] out_o;
    logic [LW-1:0] lat_o;

    sva_bounded_response_monitor #(
      .MIN_DLY(MIN), .MAX_DLY(MAX), .NONOVERLAP(NO), .MAX_OUTST(MO), .CNT_W(CW)
    ) dut (
      .clk(clk), .rst(rst), .en(en), .clear_i(clear), .trig_i(trig), .ready_i(ready),
      .pass_o(p_o), .fail_o(f_o), .pass_cnt_o(pc_o), .fail_cnt_o(fc_o),
      .outstanding_o(out_o), .overflow_o(ovf_o), .last_lat_o(lat_o)
    );

    assign obs_p[k]   = p_o;
    assign obs_f[k]   = f_o;
    assign obs_ovf[k] = ovf_o;
    assign obs_pc[k]  = 32'(pc_o);
    assign obs_fc[k]  = 32'(fc_o);
    assign obs_out[k] = 32'(out_o);
    assign obs_lat[k] = 32'(lat_o);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each instance keeps a list of open attempts by birth edge.
  int emin_m [NK], emax_m [NK], mo_m [NK], cmax_m [NK];
  int birth  [NK][16];
  int nopen  [NK];
  int cyc = 0;
  int exp_p [NK], exp_f [NK], exp_pc [NK], exp_fc [NK], exp_out [NK], exp_lat [NK], exp_ovf [NK];

  task automatic model_reset(input int k);
    nopen[k] = 0;
    exp_p[k] = 0; exp_f[k] = 0; exp_pc[k] = 0; exp_fc[k] = 0;
    exp_out[k] = 0; exp_lat[k] = 0; exp_ovf[k] = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      int nb [16];
      int nn, np, nf, lat, age;
      bit dropped;
      nn = 0; np = 0; nf = 0; lat = 0; dropped = 0;
      if (rst) begin
        model_reset(k);
        continue;
      end
      for (int i = 0; i < nopen[k]; i++) begin
        age = cyc - birth[k][i];
        if (ready && age >= emin_m[k] && age <= emax_m[k]) begin
          np++;
          if (age > lat) lat = age;
        end else if (!ready && age == emax_m[k]) begin
          nf++;
        end else begin
          nb[nn] = birth[k][i];
          nn++;
        end
      end
      if (trig && en) begin
        if (ready && emin_m[k] == 0) np++;
        else if (!ready && emax_m[k] == 0) nf++;
        else if (nn < mo_m[k]) begin
          nb[nn] = cyc;
          nn++;
        end else dropped = 1;
      end
      for (int i = 0; i < nn; i++) birth[k][i] = nb[i];
      nopen[k]   = nn;
      exp_p[k]   = (np > 0) ? 1 : 0;
      exp_f[k]   = (nf > 0) ? 1 : 0;
      exp_out[k] = nn;
      if (np > 0) exp_lat[k] = lat;
      if (clear) begin
        exp_pc[k] = 0; exp_fc[k] = 0; exp_ovf[k] = 0;
      end else begin
        exp_pc[k] = (exp_pc[k] + np > cmax_m[k]) ? cmax_m[k] : exp_pc[k] + np;
        exp_fc[k] = (exp_fc[k] + nf > cmax_m[k]) ? cmax_m[k] : exp_fc[k] + nf;
        if (dropped) exp_ovf[k] = 1;
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    for (int k = 0; k < NK; k++) begin
      check($sformatf("k%0d pass_o", k),        32'(obs_p[k]),   exp_p[k]);
      check($sformatf("k%0d fail_o", k),        32'(obs_f[k]),   exp_f[k]);
      check($sformatf("k%0d pass_cnt_o", k),    obs_pc[k],       exp_pc[k]);
      check($sformatf("k%0d fail_cnt_o", k),    obs_fc[k],       exp_fc[k]);
      check($sformatf("k%0d outstanding_o", k), obs_out[k],      exp_out[k]);
      check($sformatf("k%0d overflow_o", k),    32'(obs_ovf[k]), exp_ovf[k]);
      check($sformatf("k%0d last_lat_o", k),    obs_lat[k],      exp_lat[k]);
    end
  endtask

  // Inputs change only after the falling edge; outputs are sampled on the falling edge.
  task automatic step_full(input logic t, input logic r, input logic e, input logic c, input logic s);
    trig = t; ready = r; en = e; clear = c; rst = s;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic step(input logic t, input logic r);
    step_full(t, r, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step_full(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      emin_m[k] = int'(MIN_V[k*8 +: 8]) + int'(NO_V[k*8 +: 8]);
      emax_m[k] = int'(MAX_V[k*8 +: 8]) + int'(NO_V[k*8 +: 8]);
      mo_m[k]   = int'(MO_V[k*8 +: 8]);
      cmax_m[k] = (1 << int'(CW_V[k*8 +: 8])) - 1;
      model_reset(k);
    end

    do_reset();
    do_reset();
    check("reset pass_o",      32'(obs_p[0]),   0);
    check("reset pass_cnt",    obs_pc[0],       0);
    check("reset outstanding", obs_out[0],      0);
    check("reset overflow",    32'(obs_ovf[0]), 0);
    check("reset last_lat",    obs_lat[0],      0);

    // T1: immediate passes on three consecutive edges
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b1);
      check("T1 pass_o", 32'(obs_p[0]), 1);
    end
    check("T1 pass_cnt",    obs_pc[0],  3);
    check("T1 fail_cnt",    obs_fc[0],  0);
    check("T1 last_lat",    obs_lat[0], 0);
    check("T1 outstanding", obs_out[0], 0);
    step(1'b0, 1'b0);
    check("T1 pass_o drops", 32'(obs_p[0]), 0);

    // T2: timeout at age 10
    do_reset();
    step(1'b1, 1'b0);
    check("T2 outstanding", obs_out[0], 1);
    for (int j = 1; j <= 10; j++) begin
      step(1'b0, 1'b0);
      check("T2 fail_o", 32'(obs_f[0]), (j == 10) ? 1 : 0);
    end
    check("T2 fail_cnt", obs_fc[0], 1);
    step(1'b0, 1'b0);
    check("T2 fail_o drops", 32'(obs_f[0]), 0);

    // T3: first ready at age 4 wins, second at age 6 is ignored
    do_reset();
    step(1'b1, 1'b0);
    for (int j = 1; j <= 3; j++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("T3 pass_o",   32'(obs_p[0]), 1);
    check("T3 last_lat", obs_lat[0],    4);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("T3 second ready", 32'(obs_p[0]), 0);
    check("T3 pass_cnt",     obs_pc[0],     1);

    // T4: window [5:5] on instance 1
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("T4a fail_o",   32'(obs_f[1]), 1);
    check("T4a fail_cnt", obs_fc[1],     1);
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("T4b pass_cnt", obs_pc[1],  1);
    check("T4b fail_cnt", obs_fc[1],  0);
    check("T4b last_lat", obs_lat[1], 5);

    // T5: non-overlapping window on instance 2
    do_reset();
    step(1'b1, 1'b1);
    check("T5 no pass at age 0", 32'(obs_p[2]), 0);
    check("T5 outstanding",      obs_out[2],    1);
    step(1'b0, 1'b1);
    check("T5 pass_o",   32'(obs_p[2]), 1);
    check("T5 last_lat", obs_lat[2],    1);

    // T6: two slots, three triggers on instance 3
    do_reset();
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
    check("T6 overflow",    32'(obs_ovf[3]), 1);
    check("T6 outstanding", obs_out[3],      2);
    for (int j = 0; j < 10; j++) step(1'b0, 1'b0);
    check("T6 fail_cnt",       obs_fc[3],       2);
    check("T6 drained",        obs_out[3],      0);
    check("T6 overflow stays", 32'(obs_ovf[3]), 1);
    step_full(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("clear fail_cnt", obs_fc[3],       0);
    check("clear overflow", 32'(obs_ovf[3]), 0);

    do_reset();
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    step_full(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("T6 rst fail_o",      32'(obs_f[3]),   0);
    check("T6 rst outstanding", obs_out[3],      0);
    check("T6 rst overflow",    32'(obs_ovf[3]), 0);
    for (int j = 0; j < 12; j++) step(1'b0, 1'b0);
    check("T6 no late fail", obs_fc[3],  0);
    check("T6 still empty",  obs_out[3], 0);

    // Counter saturation on the 3-bit instance
    do_reset();
    for (int j = 0; j < 10; j++) step(1'b1, 1'b1);
    check("sat pass_cnt k3", obs_pc[3], 7);
    check("sat pass_cnt k0", obs_pc[0], 10);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step_full($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) != 0, $urandom_range(0, 99) < 2,
                $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
